regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_if.sv | 35 +++
 rtl/regfile_sb.sv | 128 ++++++++++++
 tb/tb_regfile_sb.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Register-file port bundle.
// Carries write-back, the read ports, issue and clear control.
interface regfile_sb_if #(
  parameter int DW = 64,
  parameter int AW = 5
);
  logic          wen;
  logic [AW-1:0] rD;
  logic [DW-1:0] din;
  logic [2:0]    ppp;
  logic [AW-1:0] rA;
  logic [AW-1:0] rB;
  logic [DW-1:0] doutA;
  logic [DW-1:0] doutB;
  logic          rdyA;
  logic          rdyB;
  logic          iss_v;
  logic [AW-1:0] iss_rd;
  logic          clr;
  logic          clr_busy;

  modport master (
    output wen, rD, din, ppp, rA, rB,
    output iss_v, iss_rd, clr,
    input  doutA, doutB, rdyA, rdyB,
    input  clr_busy
  );

  modport slave (
    input  wen, rD, din, ppp, rA, rB,
    input  iss_v, iss_rd, clr,
    output doutA, doutB, rdyA, rdyB,
    output clr_busy
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with masked write-back, forwarding,
// a busy scoreboard and a sequential clear engine.
module regfile_sb #(
  parameter int DW   = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q;
  logic [DW-1:0]   rf [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [DW-1:0]   wmask;
  logic            idle;
  logic            wr;
  logic            hitA, hitB;

  // Byte/bit numbering is MSB-first: byte 0 is the top byte.
  function automatic logic [DW-1:0] mask_of(
    input logic [2:0] p
  );
    logic [DW-1:0] m;
    m = '0;
    case (p)
      3'b000: m = '1;
      3'b001: m[DW-1:DW/2] = '1;
      3'b010: m[DW/2-1:0] = '1;
      3'b011,
      3'b100: begin
        for (int k = 0; k < DW/8; k++)
          if (k[0] == p[2])
            m[DW-1-8*k -: 8] = 8'hFF;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

  assign idle  = (state_q == IDLE);
  assign wr    = idle && bus.wen && (bus.rD != '0);
  assign wmask = mask_of(bus.ppp);
  assign hitA  = idle && bus.wen && (bus.rD == bus.rA);
  assign hitB  = idle && bus.wen && (bus.rD == bus.rB);

  always_comb begin
    state_d      = state_q;
    bus.clr_busy = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.clr)
          state_d = CLEAR;
      end
      CLEAR: begin
        bus.clr_busy = 1'b1;
        if (cnt_q == AW'(NREG-1))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      if (idle)
        cnt_q <= AW'(1);
      else
        cnt_q <= cnt_q + AW'(1);
    end
  end

  // Register 0 is never written: wr excludes it, cnt starts at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else if (wr) begin
      rf[bus.rD] <= (rf[bus.rD] & ~wmask)
                  | (bus.din & wmask);
    end else if (!idle) begin
      rf[cnt_q] <= '0;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (wr)
      busy_d[bus.rD] = 1'b0;
    if (bus.iss_v && (bus.iss_rd != '0))
      busy_d[bus.iss_rd] = 1'b1;
    if (bus.clr)
      busy_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      busy_q <= '0;
    else if (idle)
      busy_q <= busy_d;
  end

  always_comb begin
    bus.doutA = '0;
    bus.doutB = '0;
    if (bus.rA != '0)
      bus.doutA = hitA
        ? (rf[bus.rA] & ~wmask) | (bus.din & wmask)
        : rf[bus.rA];
    if (bus.rB != '0)
      bus.doutB = hitB
        ? (rf[bus.rB] & ~wmask) | (bus.din & wmask)
        : rf[bus.rB];
    bus.rdyA = idle && ((bus.rA == '0)
             || !busy_q[bus.rA] || hitA);
    bus.rdyB = idle && ((bus.rB == '0)
             || !busy_q[bus.rB] || hitB);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, clear/reset
// sequences, and random traffic against a behavioural model.
module tb_regfile_sb;
  localparam int DW   = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_sb_if #(.DW(DW), .AW(AW)) bus();

  regfile_sb #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] m_rf [NREG];
  bit          m_busy [NREG];
  bit          m_clr;
  int          m_idx;

  typedef struct {
    logic        wen;
    logic [4:0]  rD;
    logic [63:0] din;
    logic [2:0]  ppp;
    logic [4:0]  rA;
    logic [4:0]  rB;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic [63:0] eA;
    logic [63:0] eB;
    logic        yA;
    logic        yB;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Built byte by byte, MSB-first, from the field-select rules.
  function automatic logic [63:0] mmask(input logic [2:0] p);
    logic [63:0] m;
    bit sel;
    m = 64'd0;
    for (int b = 0; b < 8; b++) begin
      case (p)
        3'd0:    sel = 1'b1;
        3'd1:    sel = (b < 4);
        3'd2:    sel = (b >= 4);
        3'd3:    sel = (b % 2 == 0);
        3'd4:    sel = (b % 2 == 1);
        default: sel = 1'b0;
      endcase
      m = {m[55:0], sel ? 8'hFF : 8'h00};
    end
    return m;
  endfunction

  task automatic m_read(input logic [4:0] a,
                        output logic [63:0] d, output logic r);
    logic [63:0] mk;
    bit hit;
    mk = mmask(bus.ppp);
    if (m_clr) begin
      d = m_rf[a];
      r = 1'b0;
    end else if (a == 5'd0) begin
      d = 64'd0;
      r = 1'b1;
    end else begin
      hit = bus.wen && (bus.rD == a);
      d = hit ? ((m_rf[a] & ~mk) | (bus.din & mk)) : m_rf[a];
      r = !m_busy[a] || hit;
    end
  endtask

  task automatic m_edge();
    logic [63:0] mk;
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        m_rf[i] = 64'd0;
        m_busy[i] = 1'b0;
      end
      m_clr = 1'b0;
      m_idx = 1;
    end else if (m_clr) begin
      m_rf[m_idx] = 64'd0;
      m_idx++;
      if (m_idx == NREG) m_clr = 1'b0;
    end else begin
      if (bus.wen && bus.rD != 5'd0) begin
        mk = mmask(bus.ppp);
        m_rf[bus.rD] = (m_rf[bus.rD] & ~mk) | (bus.din & mk);
        m_busy[bus.rD] = 1'b0;
      end
      if (bus.iss_v && bus.iss_rd != 5'd0)
        m_busy[bus.iss_rd] = 1'b1;
      if (bus.clr) begin
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        m_clr = 1'b1;
        m_idx = 1;
      end
    end
  endtask

  task automatic cyc(output logic cb);
    logic [63:0] d;
    logic r;
    #1;
    m_read(bus.rA, d, r);
    chk("doutA", bus.doutA, d);
    chk("rdyA", bus.rdyA, r);
    m_read(bus.rB, d, r);
    chk("doutB", bus.doutB, d);
    chk("rdyB", bus.rdyB, r);
    chk("clr_busy", bus.clr_busy, m_clr);
    cb = bus.clr_busy;
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle_in();
    bus.wen = 0; bus.rD = 0; bus.din = 0; bus.ppp = 0;
    bus.rA = 0; bus.rB = 0; bus.iss_v = 0; bus.iss_rd = 0;
    bus.clr = 0;
  endtask

  task automatic rand_in();
    bus.wen = 1'($urandom);
    bus.rD = 5'($urandom);
    bus.din = {$urandom, $urandom};
    bus.ppp = 3'($urandom);
    bus.rA = ($urandom_range(0, 2) == 0) ? bus.rD : 5'($urandom);
    bus.rB = ($urandom_range(0, 2) == 0) ? bus.rD : 5'($urandom);
    bus.iss_v = 1'($urandom);
    bus.iss_rd = ($urandom_range(0, 3) == 0) ? bus.rD : 5'($urandom);
    bus.clr = 0;
  endtask

  task automatic scan_zero(input string nm);
    logic cb;
    for (int r = 0; r < NREG; r++) begin
      idle_in();
      bus.rA = 5'(r);
      bus.rB = 5'(NREG - 1 - r);
      cyc(cb);
      chk({nm, "_dout"}, bus.doutA, 64'd0);
      chk({nm, "_rdy"}, bus.rdyA, 1'b1);
    end
  endtask

  vec_t tv [16];

  initial begin
    logic cb;
    tv[0]  = '{1'b1, 5'd3, 64'h0123456789ABCDEF, 3'd0, 5'd3, 5'd0, 1'b0, 5'd0,
               64'h0123456789ABCDEF, 64'd0, 1'b1, 1'b1};
    tv[1]  = '{1'b0, 5'd0, 64'd0, 3'd0, 5'd3, 5'd0, 1'b0, 5'd0,
               64'h0123456789ABCDEF, 64'd0, 1'b1, 1'b1};
    tv[2]  = '{1'b1, 5'd3, 64'hFFFFFFFFFFFFFFFF, 3'd3, 5'd3, 5'd3, 1'b0, 5'd0,
               64'hFF23FF67FFABFFEF, 64'hFF23FF67FFABFFEF, 1'b1, 1'b1};
    tv[3]  = '{1'b0, 5'd0, 64'd0, 3'd0, 5'd3, 5'd3, 1'b0, 5'd0,
               64'hFF23FF67FFABFFEF, 64'hFF23FF67FFABFFEF, 1'b1, 1'b1};
    tv[4]  = '{1'b0, 5'd0, 64'd0, 3'd0, 5'd5, 5'd0, 1'b1, 5'd5,
               64'd0, 64'd0, 1'b1, 1'b1};
    tv[5]  = '{1'b0, 5'd0, 64'd0, 3'd0, 5'd5, 5'd0, 1'b0, 5'd0,
               64'd0, 64'd0, 1'b0, 1'b1};
    tv[6]  = '{1'b1, 5'd5, 64'hAAAAAAAAAAAAAAAA, 3'd0, 5'd5, 5'd5, 1'b0, 5'd0,
               64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA, 1'b1, 1'b1};
    tv[7]  = '{1'b0, 5'd0, 64'd0, 3'd0, 5'd5, 5'd5, 1'b0, 5'd0,
               64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA, 1'b1, 1'b1};
    tv[8]  = '{1'b1, 5'd7, 64'h1111111111111111, 3'd0, 5'd7, 5'd0, 1'b1, 5'd7,
               64'h1111111111111111, 64'd0, 1'b1, 1'b1};
    tv[9]  = '{1'b0, 5'd0, 64'd0, 3'd0, 5'd7, 5'd0, 1'b0, 5'd0,
               64'h1111111111111111, 64'd0, 1'b0, 1'b1};
    tv[10] = '{1'b1, 5'd7, 64'hFFFFFFFFFFFFFFFF, 3'd5, 5'd7, 5'd0, 1'b0, 5'd0,
               64'h1111111111111111, 64'd0, 1'b1, 1'b1};
    tv[11] = '{1'b0, 5'd0, 64'd0, 3'd0, 5'd7, 5'd0, 1'b0, 5'd0,
               64'h1111111111111111, 64'd0, 1'b1, 1'b1};
    tv[12] = '{1'b1, 5'd9, 64'hFFFFFFFFFFFFFFFF, 3'd1, 5'd9, 5'd9, 1'b0, 5'd0,
               64'hFFFFFFFF00000000, 64'hFFFFFFFF00000000, 1'b1, 1'b1};
    tv[13] = '{1'b1, 5'd9, 64'h123456789ABCDEF0, 3'd2, 5'd9, 5'd9, 1'b0, 5'd0,
               64'hFFFFFFFF9ABCDEF0, 64'hFFFFFFFF9ABCDEF0, 1'b1, 1'b1};
    tv[14] = '{1'b1, 5'd9, 64'd0, 3'd4, 5'd9, 5'd9, 1'b0, 5'd0,
               64'hFF00FF009A00DE00, 64'hFF00FF009A00DE00, 1'b1, 1'b1};
    tv[15] = '{1'b1, 5'd0, 64'hFFFFFFFFFFFFFFFF, 3'd0, 5'd0, 5'd9, 1'b0, 5'd0,
               64'd0, 64'hFF00FF009A00DE00, 1'b1, 1'b1};

    reset = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    m_edge();
    #1;
    reset = 1'b0;
    bus.rA = 5'd3;
    bus.rB = 5'd31;
    #1;
    chk("rst_doutA", bus.doutA, 64'd0);
    chk("rst_doutB", bus.doutB, 64'd0);
    chk("rst_rdyA", bus.rdyA, 1'b1);
    chk("rst_rdyB", bus.rdyB, 1'b1);
    chk("rst_clr_busy", bus.clr_busy, 1'b0);

    foreach (tv[i]) begin
      bus.wen = tv[i].wen;   bus.rD = tv[i].rD;
      bus.din = tv[i].din;   bus.ppp = tv[i].ppp;
      bus.rA = tv[i].rA;     bus.rB = tv[i].rB;
      bus.iss_v = tv[i].iss_v; bus.iss_rd = tv[i].iss_rd;
      bus.clr = 1'b0;
      #1;
      chk($sformatf("vec%0d_doutA", i), bus.doutA, tv[i].eA);
      chk($sformatf("vec%0d_doutB", i), bus.doutB, tv[i].eB);
      chk($sformatf("vec%0d_rdyA", i), bus.rdyA, tv[i].yA);
      chk($sformatf("vec%0d_rdyB", i), bus.rdyB, tv[i].yB);
      @(posedge clk);
      m_edge();
      #1;
    end

    // Full clear, with a write landing in the same cycle as clr.
    for (int r = 1; r < NREG; r++) begin
      idle_in();
      bus.wen = 1'b1; bus.rD = 5'(r); bus.rA = 5'(r);
      bus.din = {$urandom | 32'd1, $urandom};
      bus.iss_v = 1'b1; bus.iss_rd = 5'(r ^ 1);
      cyc(cb);
    end
    idle_in();
    bus.wen = 1'b1; bus.rD = 5'd4; bus.rA = 5'd4;
    bus.din = 64'hFFFFFFFFFFFFFFFF; bus.clr = 1'b1;
    cyc(cb);
    for (int k = 0; k < NREG - 1; k++) begin
      rand_in();
      bus.clr = 1'($urandom);
      cyc(cb);
      chk($sformatf("clr_len_c%0d", k), cb, 1'b1);
    end
    idle_in();
    cyc(cb);
    chk("clr_done", cb, 1'b0);
    scan_zero("clr_zero");

    // Reset arriving on the tenth clear cycle.
    for (int r = 1; r < 9; r++) begin
      idle_in();
      bus.wen = 1'b1; bus.rD = 5'(r);
      bus.din = {$urandom | 32'd1, $urandom};
      cyc(cb);
    end
    idle_in();
    bus.clr = 1'b1;
    cyc(cb);
    for (int k = 0; k < 9; k++) begin
      rand_in();
      cyc(cb);
    end
    rand_in();
    reset = 1'b1;
    cyc(cb);
    reset = 1'b0;
    idle_in();
    #1;
    chk("rst_abort_clr_busy", bus.clr_busy, 1'b0);
    scan_zero("rst_abort_zero");

    for (int n = 0; n < 1500; n++) begin
      rand_in();
      bus.clr = ($urandom_range(0, 79) == 0);
      reset = ($urandom_range(0, 299) == 0);
      cyc(cb);
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
